// File: rtl/uart_pkg.sv
// Shared UART definitions: receiver state encoding, oversampling ratio and
// character widths used by both the receive and transmit datapaths.
package uart_pkg;

  localparam int OVERSAMPLE   = 16;
  localparam int CNT_W        = $clog2(OVERSAMPLE);
  localparam int DATA_W       = 8;
  localparam int DATA_W_SHORT = 7;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    PARITY,
    STOP,
    WAIT_HIGH
  } rx_state_e;

  function automatic logic majority3(input logic [2:0] v);
    return (v[0] & v[1]) | (v[0] & v[2]) | (v[1] & v[2]);
  endfunction

endpackage

// File: rtl/uart_rx_filter.sv
// Two-flop synchroniser followed by a 3-tap majority vote clocked by the
// oversampling tick; usable for any slow asynchronous input such as CTS.
module uart_rx_filter
  import uart_pkg::*;
(
  input  logic clk_i,
  input  logic rst_i,
  input  logic tick_i,
  input  logic din_i,
  output logic filt_o
);

  logic [1:0] sync_q;
  logic [2:0] taps_q;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      sync_q <= 2'b11;
      taps_q <= 3'b111;
    end else begin
      sync_q <= {sync_q[0], din_i};
      if (tick_i) taps_q <= {taps_q[1:0], sync_q[1]};
    end
  end

  assign filt_o = majority3(taps_q);

endmodule

// File: rtl/uart_rx_async.sv
// UART receiver: start detection, mid-bit sampling on a 16x tick, parity and
// stop checks, and delivery to a holding register or an external FIFO.
module uart_rx_async
  import uart_pkg::*;
#(
  parameter int RX_FIFO      = 0,
  parameter int SAMPLE_POINT = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              baud_clock,
  input  logic              rx,
  input  logic              bit8,
  input  logic              parity_en,
  input  logic              odd_n_even,
  input  logic              read_rx_byte,
  input  logic              fifo_full,
  output logic [DATA_W-1:0] rx_byte,
  output logic              rx_rdy,
  output logic              rx_wr_en,
  output logic              parity_err,
  output logic              framing_err,
  output logic              overflow
);

  localparam logic [CNT_W-1:0] SAMPLE_CNT = CNT_W'(SAMPLE_POINT);
  localparam logic [CNT_W-1:0] LAST_CNT   = CNT_W'(OVERSAMPLE - 1);

  logic              filt;
  rx_state_e         state_q;
  logic [CNT_W-1:0]  cnt_q;
  logic [2:0]        bitcnt_q;
  logic [DATA_W-1:0] shift_q;
  logic              bit8_q, par_en_q, odd_q;
  logic              frame_perr_q, frame_ferr_q;
  logic              deliver_q;
  logic [DATA_W-1:0] frame_byte_d;
  logic [2:0]        last_bit_d;
  logic              wrap_d;

  uart_rx_filter u_filt (
    .clk_i  (clk),
    .rst_i  (reset),
    .tick_i (baud_clock),
    .din_i  (rx),
    .filt_o (filt)
  );

  // In 7-bit frames the character lands in the upper seven shift positions.
  assign frame_byte_d = bit8_q ? shift_q : {1'b0, shift_q[DATA_W-1:1]};
  assign last_bit_d   = bit8_q ? 3'(DATA_W - 1) : 3'(DATA_W_SHORT - 1);
  assign wrap_d       = (cnt_q == LAST_CNT);

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= IDLE;
      cnt_q        <= '0;
      bitcnt_q     <= '0;
      shift_q      <= '0;
      bit8_q       <= 1'b0;
      par_en_q     <= 1'b0;
      odd_q        <= 1'b0;
      frame_perr_q <= 1'b0;
      frame_ferr_q <= 1'b0;
      deliver_q    <= 1'b0;
    end else begin
      deliver_q <= 1'b0;
      if (baud_clock) begin
        case (state_q)
          IDLE: begin
            if (!filt) begin
              cnt_q   <= '0;
              state_q <= START;
            end
          end
          START: begin
            if (cnt_q == SAMPLE_CNT) begin
              if (filt) begin
                state_q <= IDLE;
              end else begin
                cnt_q        <= '0;
                bitcnt_q     <= '0;
                frame_perr_q <= 1'b0;
                frame_ferr_q <= 1'b0;
                bit8_q       <= bit8;
                par_en_q     <= parity_en;
                odd_q        <= odd_n_even;
                state_q      <= DATA;
              end
            end else begin
              cnt_q <= cnt_q + 1'b1;
            end
          end
          // The counter wraps every OVERSAMPLE ticks, landing each sample
          // SAMPLE_POINT ticks into its bit.
          DATA: begin
            cnt_q <= cnt_q + 1'b1;
            if (wrap_d) begin
              shift_q <= {filt, shift_q[DATA_W-1:1]};
              if (bitcnt_q == last_bit_d) state_q <= par_en_q ? PARITY : STOP;
              else bitcnt_q <= bitcnt_q + 1'b1;
            end
          end
          PARITY: begin
            cnt_q <= cnt_q + 1'b1;
            if (wrap_d) begin
              frame_perr_q <= ((^frame_byte_d) ^ filt) != odd_q;
              state_q      <= STOP;
            end
          end
          STOP: begin
            cnt_q <= cnt_q + 1'b1;
            if (wrap_d) begin
              frame_ferr_q <= !filt;
              deliver_q    <= 1'b1;
              state_q      <= filt ? IDLE : WAIT_HIGH;
            end
          end
          WAIT_HIGH: begin
            if (filt) state_q <= IDLE;
          end
          default: state_q <= IDLE;
        endcase
      end
    end
  end

  // A delivery coinciding with a host read wins: flags then describe only
  // the new character.
  always_ff @(posedge clk) begin
    if (reset) begin
      rx_byte     <= '0;
      rx_rdy      <= 1'b0;
      rx_wr_en    <= 1'b0;
      parity_err  <= 1'b0;
      framing_err <= 1'b0;
      overflow    <= 1'b0;
    end else begin
      rx_wr_en <= 1'b0;
      if (deliver_q) begin
        rx_byte     <= frame_byte_d;
        parity_err  <= frame_perr_q | (parity_err & !read_rx_byte);
        framing_err <= frame_ferr_q | (framing_err & !read_rx_byte);
        if (RX_FIFO != 0) begin
          rx_wr_en <= !fifo_full;
          overflow <= fifo_full | (overflow & !read_rx_byte);
        end else begin
          rx_rdy   <= 1'b1;
          overflow <= (overflow | rx_rdy) & !read_rx_byte;
        end
      end else if (read_rx_byte) begin
        rx_rdy      <= 1'b0;
        parity_err  <= 1'b0;
        framing_err <= 1'b0;
        overflow    <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_uart_rx_async.sv
// Bench for uart_rx_async: a holding-register instance and a FIFO-mode
// instance share the serial line; frames are modelled at character level.
module tb_uart_rx_async;

  logic clk = 1'b0;
  logic reset, baud_clock, rx, bit8, parity_en, odd_n_even;
  logic fifo_full1;
  logic mon_rd0 = 1'b0, stim_rd0 = 1'b0, mon_rd1 = 1'b0, stim_rd1 = 1'b0;
  logic rd0, rd1;
  logic [7:0] rx_byte0, rx_byte1;
  logic rx_rdy0, rx_wr_en0, parity_err0, framing_err0, overflow0;
  logic rx_rdy1, rx_wr_en1, parity_err1, framing_err1, overflow1;

  assign rd0 = mon_rd0 | stim_rd0;
  assign rd1 = mon_rd1 | stim_rd1;

  uart_rx_async #(.RX_FIFO(0), .SAMPLE_POINT(8)) dut0 (
    .clk(clk), .reset(reset), .baud_clock(baud_clock), .rx(rx), .bit8(bit8),
    .parity_en(parity_en), .odd_n_even(odd_n_even), .read_rx_byte(rd0),
    .fifo_full(1'b0), .rx_byte(rx_byte0), .rx_rdy(rx_rdy0), .rx_wr_en(rx_wr_en0),
    .parity_err(parity_err0), .framing_err(framing_err0), .overflow(overflow0));

  uart_rx_async #(.RX_FIFO(1), .SAMPLE_POINT(8)) dut1 (
    .clk(clk), .reset(reset), .baud_clock(baud_clock), .rx(rx), .bit8(bit8),
    .parity_en(parity_en), .odd_n_even(odd_n_even), .read_rx_byte(rd1),
    .fifo_full(fifo_full1), .rx_byte(rx_byte1), .rx_rdy(rx_rdy1), .rx_wr_en(rx_wr_en1),
    .parity_err(parity_err1), .framing_err(framing_err1), .overflow(overflow1));

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // 16x tick: one clk in four
  initial begin
    baud_clock = 1'b0;
    forever begin
      @(negedge clk);
      baud_clock = (cyc % 4 == 3);
    end
  end

  typedef struct packed {
    logic [7:0] b;
    logic       pe;
    logic       fe;
  } exp_t;

  exp_t q0[$];
  exp_t q1[$];
  int  checks = 0;
  int  failures = 0;
  bit  push0 = 1'b1, push1 = 1'b1, autoread = 1'b1;
  int  t_start = 0, t_wr = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, req);
    end
  endtask

  // Holding-register host: reads each character as soon as it is flagged.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (autoread && rx_rdy0 && !reset) begin
        if (q0.size() == 0) begin
          check("rx0_unexpected_byte", 32'(q0.size()), 32'd1);
        end else begin
          e = q0.pop_front();
          check("rx0_byte", 32'(rx_byte0), 32'(e.b));
          check("rx0_parity_err", 32'(parity_err0), 32'(e.pe));
          check("rx0_framing_err", 32'(framing_err0), 32'(e.fe));
          check("rx0_overflow", 32'(overflow0), 32'd0);
        end
        mon_rd0 = 1'b1;
        @(negedge clk);
        mon_rd0 = 1'b0;
      end
    end
  end

  // FIFO-side consumer: every write strobe must match the next expected character.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (rx_wr_en1) begin
        t_wr = cyc;
        if (q1.size() == 0) begin
          check("rx1_unexpected_write", 32'(q1.size()), 32'd1);
        end else begin
          e = q1.pop_front();
          check("rx1_byte", 32'(rx_byte1), 32'(e.b));
          check("rx1_parity_err", 32'(parity_err1), 32'(e.pe));
          check("rx1_framing_err", 32'(framing_err1), 32'(e.fe));
        end
        mon_rd1 = 1'b1;
        @(negedge clk);
        mon_rd1 = 1'b0;
      end
    end
  end

  task automatic drive_bit(input logic v, input bit spike);
    rx = v;
    if (spike) begin
      repeat (36) @(negedge clk);
      rx = ~v;
      repeat (4) @(negedge clk);
      rx = v;
      repeat (24) @(negedge clk);
    end else begin
      repeat (64) @(negedge clk);
    end
  endtask

  task automatic idle(input int nbits);
    rx = 1'b1;
    repeat (nbits * 64) @(negedge clk);
  endtask

  task automatic send_frame(input logic [7:0] d, input bit b8, input bit pen, input bit odd,
                            input bit flip, input logic stopv, input int spike_idx,
                            input int low_after);
    exp_t e;
    logic p;
    int   nb;
    nb = b8 ? 8 : 7;
    while (cyc % 4 != 0) @(negedge clk);
    bit8 = b8; parity_en = pen; odd_n_even = odd;
    e.b  = b8 ? d : {1'b0, d[6:0]};
    p    = (^e.b) ^ odd ^ flip;
    e.pe = pen & flip;
    e.fe = ~stopv;
    if (push0) q0.push_back(e);
    if (push1) q1.push_back(e);
    t_start = cyc;
    drive_bit(1'b0, 1'b0);
    // settings wander during the frame; the character format must not follow
    bit8 = 1'($urandom); parity_en = 1'($urandom); odd_n_even = 1'($urandom);
    for (int i = 0; i < nb; i++) drive_bit(d[i], i == spike_idx);
    if (pen) drive_bit(p, 1'b0);
    drive_bit(stopv, 1'b0);
    repeat (low_after) drive_bit(1'b0, 1'b0);
    rx = 1'b1;
  endtask

  task automatic drain();
    int n = 0;
    while ((q0.size() != 0 || q1.size() != 0) && n < 3000) begin
      @(negedge clk);
      n++;
    end
    check("drain_pending", 32'(q0.size() + q1.size()), 32'd0);
    repeat (4) @(negedge clk);
  endtask

  task automatic pulse_rd0();
    stim_rd0 = 1'b1;
    @(negedge clk);
    stim_rd0 = 1'b0;
    @(negedge clk);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int lat, ts;
    logic [7:0] d;
    reset = 1'b1; rx = 1'b1; bit8 = 1'b1; parity_en = 1'b0; odd_n_even = 1'b0;
    fifo_full1 = 1'b0;
    repeat (4) @(negedge clk);
    check("reset_out0", 32'({rx_byte0, rx_rdy0, rx_wr_en0, parity_err0, framing_err0, overflow0}), 32'd0);
    check("reset_out1", 32'({rx_byte1, rx_rdy1, rx_wr_en1, parity_err1, framing_err1, overflow1}), 32'd0);
    reset = 1'b0;
    idle(2);

    send_frame(8'hA5, 1, 0, 0, 0, 1'b1, -1, 0);
    idle(1); drain();

    send_frame(8'h41, 0, 1, 0, 1, 1'b1, -1, 0);
    idle(1); drain();
    check("7e1_cleared", 32'({rx_rdy0, parity_err0}), 32'd0);

    // short low pulse: must be rejected as a false start
    while (cyc % 4 != 0) @(negedge clk);
    rx = 1'b0;
    repeat (20) @(negedge clk);
    idle(3);
    check("glitch_flags0", 32'({rx_rdy0, parity_err0, framing_err0, overflow0}), 32'd0);
    check("glitch_no_write", 32'({rx_wr_en1, parity_err1, framing_err1, overflow1}), 32'd0);

    send_frame(8'h3C, 1, 0, 0, 0, 1'b1, 2, 0);
    idle(1); drain();
    send_frame(8'h3C, 1, 0, 0, 0, 1'b1, 6, 0);
    idle(1); drain();

    for (int k = 0; k < 10; k++) begin
      d = 8'($urandom);
      send_frame(d, 1'($urandom), 1'($urandom), 1'($urandom), ($urandom % 4) == 0, 1'b1, -1, 0);
      idle(1 + int'($urandom % 2)); drain();
    end

    // overrun: two characters without a read
    autoread = 1'b0; push0 = 1'b0;
    send_frame(8'h55, 1, 0, 0, 0, 1'b1, -1, 0);
    lat = t_wr - t_start;
    send_frame(8'hAA, 1, 0, 0, 0, 1'b1, -1, 0);
    idle(1); drain();
    check("ovf_byte", 32'(rx_byte0), 32'hAA);
    check("ovf_flag", 32'(overflow0), 32'd1);
    check("ovf_rdy", 32'(rx_rdy0), 32'd1);
    pulse_rd0();
    check("ovf_cleared", 32'({rx_rdy0, overflow0}), 32'd0);

    // read lands on the exact delivery cycle of the second character
    send_frame(8'h55, 1, 0, 0, 0, 1'b1, -1, 0);
    idle(1); drain();
    while (cyc % 4 != 0) @(negedge clk);
    ts = cyc;
    fork
      send_frame(8'hAA, 1, 0, 0, 0, 1'b1, -1, 0);
      begin
        while (cyc < ts + lat - 1) @(negedge clk);
        stim_rd0 = 1'b1;
        @(negedge clk);
        stim_rd0 = 1'b0;
      end
    join
    idle(1); drain();
    check("coinc_rdy", 32'(rx_rdy0), 32'd1);
    check("coinc_ovf", 32'(overflow0), 32'd0);
    check("coinc_byte", 32'(rx_byte0), 32'hAA);
    check("coinc_errs", 32'({parity_err0, framing_err0}), 32'd0);
    pulse_rd0();
    autoread = 1'b1; push0 = 1'b1;

    // break: stop bit low and line held low for 40 bit times
    send_frame(8'h96, 1, 0, 0, 0, 1'b0, -1, 40);
    idle(2); drain();
    send_frame(8'h0F, 1, 0, 0, 0, 1'b1, -1, 0);
    idle(1); drain();

    // FIFO full at delivery: write suppressed, overflow raised
    fifo_full1 = 1'b1; push1 = 1'b0;
    send_frame(8'hC3, 1, 1, 1, 0, 1'b1, -1, 0);
    idle(1); drain();
    fifo_full1 = 1'b0; push1 = 1'b1;
    check("fifo_full_ovf", 32'(overflow1), 32'd1);
    check("fifo_full_ovf0", 32'(overflow0), 32'd0);
    stim_rd1 = 1'b1;
    @(negedge clk);
    stim_rd1 = 1'b0;
    @(negedge clk);
    check("fifo_ovf_cleared", 32'(overflow1), 32'd0);

    // reset in the middle of a data bit
    autoread = 1'b0; push0 = 1'b0;
    send_frame(8'h5A, 1, 0, 0, 0, 1'b1, -1, 0);
    idle(1); drain();
    check("pre_reset_rdy", 32'(rx_rdy0), 32'd1);
    push1 = 1'b0;
    while (cyc % 4 != 0) @(negedge clk);
    drive_bit(1'b0, 1'b0);
    drive_bit(1'b1, 1'b0);
    drive_bit(1'b0, 1'b0);
    rx = 1'b1;
    repeat (30) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    check("midreset_out0", 32'({rx_byte0, rx_rdy0, rx_wr_en0, parity_err0, framing_err0, overflow0}), 32'd0);
    check("midreset_out1", 32'({rx_byte1, rx_rdy1, rx_wr_en1, parity_err1, framing_err1, overflow1}), 32'd0);
    reset = 1'b0;
    idle(3);
    autoread = 1'b1; push0 = 1'b1; push1 = 1'b1;
    send_frame(8'h81, 1, 1, 0, 0, 1'b1, -1, 0);
    idle(1); drain();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/uart_rx_async.md
Name: uart_rx_async

Overview:
Asynchronous UART receiver. It is the receive-side counterpart to the UART transmitter in the CoreUARTapb datapath.
- Synchronises and filters the serial line, detects the start bit and samples data at mid-bit using a 16x baud tick.
- Checks parity and stop bit, then presents the byte to the APB register block with ready, overflow, parity-error and framing-error flags.
- Sits between the pad input and the APB/FIFO logic, sharing the baud generator with the transmitter.

Parameters:
- RX_FIFO, 0: 0 = single holding register with rx_rdy/overflow semantics; 1 = pulse rx_wr_en per byte toward an external FIFO (overflow then driven by FIFO full).
- SAMPLE_POINT, 8: oversample count (0..15) at which a bit is sampled.

Ports:
- clk  in  1  system clock
- reset  in  1  synchronous, active-high reset
- baud_clock  in  1  one-clk-wide enable at 16x the bit rate
- rx  in  1  raw serial input, idle high
- bit8  in  1  1 = 8 data bits, 0 = 7 data bits
- parity_en  in  1  parity bit present and checked
- odd_n_even  in  1  1 = odd parity, 0 = even parity
- read_rx_byte  in  1  one-clk pulse: host consumed rx_byte, clears rx_rdy and sticky errors
- fifo_full  in  1  external FIFO full (used only when RX_FIFO=1)
- rx_byte  out  8  received data, LSB first on line
- rx_rdy  out  1  byte valid (RX_FIFO=0)
- rx_wr_en  out  1  one-clk write strobe (RX_FIFO=1)
- parity_err  out  1  sticky parity error
- framing_err  out  1  sticky framing error (stop bit sampled 0)
- overflow  out  1  sticky overrun

Behaviour:
- Clock and reset: single clock domain; clk only. Reset is synchronous and active-high.
- Reset values: all outputs 0, rx_byte = 8'h00, state IDLE, synchroniser flops = 1, counters 0.
- Input filtering:
  - rx passes through 2 flops, then a 3-bit shift register updated on baud_clock.
  - The filtered bit is the majority of those 3 bits.
- State machine (advances only on baud_clock ticks):
  - IDLE: on filtered 0, clear the 4-bit oversample counter and go to START.
  - START: count to SAMPLE_POINT. If the filtered bit is 1, it is a glitch: return to IDLE. Otherwise clear the counter and go to DATA.
  - DATA: sample when the counter wraps 15->0 plus SAMPLE_POINT, i.e. every 16 ticks. Shift LSB-first into the shift register.
  - DATA bit count: 8 bits if bit8 = 1, else 7. After the last bit go to PARITY if parity_en, else STOP.
  - PARITY: sample the bit. Error if (XOR of data bits XOR sampled bit) != odd_n_even.
  - STOP: sample the bit. A value of 0 flags a framing error. Deliver the byte, then go to IDLE.
  - After a framing error (break condition), go to WAIT_HIGH. Stay there until the filtered bit is 1, then go to IDLE. This prevents re-triggering on a held-low line.
- Delivery (RX_FIFO=0), on the clk after the stop-bit sample:
  - rx_byte is loaded; rx_byte[7] = 0 in 7-bit mode.
  - rx_rdy = 1.
  - parity_err and framing_err are OR-set.
  - If rx_rdy was already 1 and read_rx_byte is not asserted that cycle, overflow = 1. The new data still overwrites rx_byte.
- Delivery (RX_FIFO=1):
  - rx_wr_en pulses for one clk with rx_byte valid.
  - If fifo_full = 1 on that cycle, overflow = 1 and the write is suppressed.
- read_rx_byte:
  - Clears rx_rdy, parity_err, framing_err and overflow on the next clk.
  - If it coincides with delivery, the delivery wins: rx_rdy = 1, error flags reflect only the new byte, overflow = 0.
- Settings changes: bit8, parity_en and odd_n_even are sampled when leaving START and held for the frame. Changing them mid-frame has no effect until the next frame.
- Reset mid-frame: returns to IDLE within one clk, discarding the partial byte and the flags.
- No baud_clock: all state holds. read_rx_byte still clears flags.

Decomposition:
- Shared package uart_pkg:
  - rx state enum: IDLE, START, DATA, PARITY, STOP, WAIT_HIGH.
  - OVERSAMPLE = 16.
  - Data-width constants, shared with the transmitter.
- One sub-module: uart_rx_filter. It contains the 2-flop synchroniser and the 3-tap majority vote, and outputs the filtered bit. It is reusable for CTS-style inputs.

Test Plan:
- 8N1, send 8'hA5 at 16x ticks → rx_byte = 8'hA5, rx_rdy rises 1 clk after the stop-bit sample, no error flags set.
- 7E1 (bit8 = 0, parity_en = 1, odd_n_even = 0), send 7'h41 with the wrong parity bit 1 → rx_byte = 8'h41, parity_err = 1. A read_rx_byte pulse then clears both.
- rx low for 5 baud ticks, then high → no byte, state back in IDLE, no flags set. Repeat with a 1-tick spike inside a data bit → the majority filter yields the correct byte 8'h3C.
- Send 8'h55 and 8'hAA back-to-back without reading → rx_byte = 8'hAA, overflow = 1. Repeat with read_rx_byte on the exact delivery cycle of the second byte → overflow = 0, rx_rdy = 1.
- Stop bit forced 0, line held low for 40 bit times, then high → framing_err = 1, exactly one byte delivered, the next valid frame 8'h0F is received correctly.
- RX_FIFO=1 with fifo_full = 1 during delivery → rx_wr_en stays 0 and overflow = 1. Also assert reset mid-DATA → all outputs 0 next clk, and the following frame is received cleanly.
